// File: rtl/shift_sched_pkg.sv
// Shared definitions for the shift scheduler.
// Holds the sequencer state encodings, the direction codes and a helper
// that computes the return-pass amount of a rotate.
package shift_sched_pkg;

  typedef enum logic [1:0] {
    SHS_IDLE  = 2'd0,
    SHS_PASS1 = 2'd1,
    SHS_PASS2 = 2'd2,
    SHS_DONE  = 2'd3
  } shs_state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Second-pass amount of a rotate: (32 - s) mod 32, zero-extended to the
  // shifter's 32-bit amount port. Only called when s != 0, so it is 1..31.
  function automatic logic [31:0] rot_back_amt(input logic [4:0] s);
    logic [4:0] back;
    back = 5'd0 - s;
    return {27'd0, back};
  endfunction

endpackage

// File: rtl/shift32.sv
// SHIFT32: combinational 32-bit logical barrel shifter.
// Ports:
//   D   in  32  operand
//   S   in  32  shift amount; any amount >= 32 yields 0
//   LNR in  1   1 = left, 0 = right
//   Y   out 32  shifted operand, vacated bits zero-filled
module SHIFT32 (
  input  logic [31:0] D,
  input  logic [31:0] S,
  input  logic        LNR,
  output logic [31:0] Y
);

  // Upper-bit detect: any set bit above bit 4 means the whole word shifts out.
  always_comb begin
    if (|S[31:5]) begin
      Y = 32'd0;
    end else if (LNR) begin
      Y = D << S[4:0];
    end else begin
      Y = D >> S[4:0];
    end
  end

endmodule

// File: rtl/shift_sched_rr_arb2.sv
// shift_rr_arb2: two-request round-robin arbiter with a registered pointer.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   REQ0, REQ1 requests
//   ACCEPT     the current grant is being taken; advances the pointer
//   GNT[1:0]   combinational one-hot grant (bit 0 = requester 0)
module shift_rr_arb2 #(
  parameter int RR_RESET_PRI = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic       ACCEPT,
  output logic [1:0] GNT
);

  // pri names the requester that wins the next tie.
  logic pri;

  always_comb begin
    GNT = 2'b00;
    if (REQ0 && REQ1) begin
      GNT = pri ? 2'b10 : 2'b01;
    end else if (REQ0) begin
      GNT = 2'b01;
    end else if (REQ1) begin
      GNT = 2'b10;
    end
  end

  // After granting requester 0 the tie goes to 1, and vice versa.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pri <= (RR_RESET_PRI != 0);
    end else if (ACCEPT && (GNT != 2'b00)) begin
      pri <= GNT[0];
    end
  end

endmodule

// File: rtl/shift_sched.sv
// shift_sched: shares one SHIFT32 between two requesters.
// Logical shifts take one shifter pass; rotates take two (shift one way,
// shift the other way by 32-S, OR the results).
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   REQ0/1               requests, held until the matching GNT
//   D0/1, S0/1           operand and shift amount
//   LNR0/1               1 = left, 0 = right
//   ROT0/1               1 = rotate, 0 = logical shift
//   GNT0/1               one-cycle pulse, operands latched
//   DONE0/1              one-cycle pulse, Y valid for that requester
//   Y                    registered result, held until the next DONE
//   BUSY                 an operation is in flight or returning its result
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int RR_RESET_PRI = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [31:0] D0,
  input  logic [31:0] D1,
  input  logic [31:0] S0,
  input  logic [31:0] S1,
  input  logic        LNR0,
  input  logic        LNR1,
  input  logic        ROT0,
  input  logic        ROT1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        DONE0,
  output logic        DONE1,
  output logic [31:0] Y,
  output logic        BUSY
);

  shs_state_t  state, state_nxt;
  logic [31:0] d_q, s_q, acc;
  logic        lnr_q, rot_q, owner_q;
  logic [1:0]  gnt_sel;
  logic        accept;
  logic [31:0] sh_amt, sh_y;
  logic        sh_dir;

  assign accept = (state == SHS_IDLE) && (REQ0 || REQ1);

  // The DONE pulse is issued from IDLE, so it is folded in to keep BUSY
  // high until the result has been handed back.
  assign BUSY = (state != SHS_IDLE) || DONE0 || DONE1;

  shift_rr_arb2 #(
    .RR_RESET_PRI(RR_RESET_PRI)
  ) u_arb (
    .CLK    (CLK),
    .RST    (RST),
    .REQ0   (REQ0),
    .REQ1   (REQ1),
    .ACCEPT (accept),
    .GNT    (gnt_sel)
  );

  // Shifter is fed only from the latched operands.
  always_comb begin
    sh_amt = s_q;
    sh_dir = lnr_q;
    if (rot_q) begin
      sh_amt = {27'd0, s_q[4:0]};
    end
    if (state == SHS_PASS2) begin
      sh_amt = rot_back_amt(s_q[4:0]);
      sh_dir = (lnr_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
    end
  end

  SHIFT32 u_shift (
    .D   (d_q),
    .S   (sh_amt),
    .LNR (sh_dir),
    .Y   (sh_y)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      SHS_IDLE:  if (accept) state_nxt = SHS_PASS1;
      // A rotate by a multiple of 32 is complete after the first pass.
      SHS_PASS1: state_nxt = (!rot_q || (s_q[4:0] == 5'd0)) ? SHS_DONE : SHS_PASS2;
      SHS_PASS2: state_nxt = SHS_DONE;
      SHS_DONE:  state_nxt = SHS_IDLE;
      default:   state_nxt = SHS_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= SHS_IDLE;
      d_q     <= 32'd0;
      s_q     <= 32'd0;
      lnr_q   <= 1'b0;
      rot_q   <= 1'b0;
      owner_q <= 1'b0;
      acc     <= 32'd0;
      Y       <= 32'd0;
      GNT0    <= 1'b0;
      GNT1    <= 1'b0;
      DONE0   <= 1'b0;
      DONE1   <= 1'b0;
    end else begin
      state <= state_nxt;
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      case (state)
        SHS_IDLE: begin
          if (accept) begin
            d_q     <= gnt_sel[1] ? D1   : D0;
            s_q     <= gnt_sel[1] ? S1   : S0;
            lnr_q   <= gnt_sel[1] ? LNR1 : LNR0;
            rot_q   <= gnt_sel[1] ? ROT1 : ROT0;
            owner_q <= gnt_sel[1];
            GNT0    <= gnt_sel[0];
            GNT1    <= gnt_sel[1];
          end
        end
        SHS_PASS1: acc <= sh_y;
        SHS_PASS2: acc <= acc | sh_y;
        SHS_DONE: begin
          Y     <= acc;
          DONE0 <= ~owner_q;
          DONE1 <= owner_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: single ops of each kind with hand-computed
// results and latencies, round-robin ordering, and reset during a rotate.
module tb_shift_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [31:0] D0 = '0, D1 = '0, S0 = '0, S1 = '0;
  logic        LNR0 = 1'b0, LNR1 = 1'b0, ROT0 = 1'b0, ROT1 = 1'b0;
  logic        GNT0, GNT1, DONE0, DONE1, BUSY;
  logic [31:0] Y;

  int errors = 0;
  int checks = 0;
  logic excl_bad = 1'b0;

  shift_sched #(.RR_RESET_PRI(0)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1),
    .D0(D0), .D1(D1), .S0(S0), .S1(S1),
    .LNR0(LNR0), .LNR1(LNR1), .ROT0(ROT0), .ROT1(ROT1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .Y(Y), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Exclusivity watch: one GNT, one DONE, and never a GNT with a DONE.
  always @(negedge CLK) begin
    if ((GNT0 && GNT1) || (DONE0 && DONE1) || ((GNT0 || GNT1) && (DONE0 || DONE1)))
      excl_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    tick; tick;
    RST = 1'b0;
  endtask

  // Issue one op, then check GNT at +1, DONE latency, Y and BUSY span.
  task automatic do_op(input string tag, input int idx, input logic [31:0] d,
                       input logic [31:0] s, input logic lnr, input logic rot,
                       input logic [31:0] exp_y, input int exp_lat);
    int lat;
    int busy_cnt;
    if (idx == 0) begin
      D0 = d; S0 = s; LNR0 = lnr; ROT0 = rot; REQ0 = 1'b1;
    end else begin
      D1 = d; S1 = s; LNR1 = lnr; ROT1 = rot; REQ1 = 1'b1;
    end
    tick;
    lat = 1;
    check({tag, " gnt"}, 32'((idx == 0) ? GNT0 : GNT1), 32'd1);
    REQ0 = 1'b0; REQ1 = 1'b0;
    busy_cnt = BUSY ? 1 : 0;
    while (!((idx == 0) ? DONE0 : DONE1) && lat < 10) begin
      tick;
      lat++;
      if (BUSY) busy_cnt++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " y"}, Y, exp_y);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    tick;
    check({tag, " busy after"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int order[$];
    int owners[$];
    int ndone;
    int cyc;
    int own;
    int lat;
    logic seen_done;

    do_reset;
    check("reset y", Y, 32'd0);
    check("reset busy", 32'(BUSY), 32'd0);
    check("reset gnt", 32'({GNT1, GNT0}), 32'd0);
    check("reset done", 32'({DONE1, DONE0}), 32'd0);

    do_op("shr4",    0, 32'hF000_0000, 32'd4,  1'b0, 1'b0, 32'h0F00_0000, 3);
    do_op("rol4",    1, 32'h8000_0001, 32'd4,  1'b1, 1'b1, 32'h0000_0018, 4);
    do_op("ror40",   0, 32'h1234_5678, 32'd40, 1'b0, 1'b1, 32'h7812_3456, 4);
    do_op("ror32",   1, 32'h1234_5678, 32'd32, 1'b0, 1'b1, 32'h1234_5678, 3);
    do_op("shl32",   0, 32'hFFFF_FFFF, 32'd32, 1'b1, 1'b0, 32'h0000_0000, 3);
    do_op("shl31",   1, 32'hFFFF_FFFF, 32'd31, 1'b1, 1'b0, 32'h8000_0000, 3);

    // Reset during PASS2; requester 0 was last granted so without the
    // reset requester 1 would win the following tie.
    D0 = 32'h8000_0001; S0 = 32'd4; LNR0 = 1'b1; ROT0 = 1'b1; REQ0 = 1'b1;
    tick;
    REQ0 = 1'b0;
    tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    check("abort y", Y, 32'd0);
    check("abort busy", 32'(BUSY), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (DONE0 || DONE1) seen_done = 1'b1;
      tick;
    end
    check("abort no done", 32'(seen_done), 32'd0);
    D0 = 32'd3; S0 = 32'd2; LNR0 = 1'b1; ROT0 = 1'b0;
    D1 = 32'hFFFF_0000; S1 = 32'd8; LNR1 = 1'b0; ROT1 = 1'b0;
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick;
    check("post-reset gnt", 32'({GNT1, GNT0}), 32'b01);
    REQ0 = 1'b0; REQ1 = 1'b0;
    lat = 1;
    while (!DONE0 && lat < 10) begin
      tick;
      lat++;
    end
    check("post-reset latency", 32'(lat), 32'd3);
    check("post-reset y", Y, 32'h0000_000C);

    // Round robin with both requests held from reset.
    do_reset;
    D0 = 32'h0000_0001; S0 = 32'd1; LNR0 = 1'b1; ROT0 = 1'b0;
    D1 = 32'h0000_0100; S1 = 32'd4; LNR1 = 1'b0; ROT1 = 1'b0;
    REQ0 = 1'b1; REQ1 = 1'b1;
    ndone = 0;
    cyc = 0;
    while (ndone < 4 && cyc < 40) begin
      tick;
      cyc++;
      if (GNT0) begin order.push_back(0); owners.push_back(0); end
      if (GNT1) begin order.push_back(1); owners.push_back(1); end
      if (order.size() >= 4) begin REQ0 = 1'b0; REQ1 = 1'b0; end
      if (DONE0 || DONE1) begin
        own = (owners.size() > 0) ? owners.pop_front() : -1;
        check("rr done owner", 32'(DONE1 ? 1 : 0), 32'(own));
        check("rr y", Y, DONE1 ? 32'h0000_0010 : 32'h0000_0002);
        ndone++;
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    check("rr done count", 32'(ndone), 32'd4);
    check("rr grant count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr order %0d", i),
            32'((i < order.size()) ? order[i] : -1), 32'(i % 2));
    end

    tick;
    check("gnt/done exclusive", 32'(excl_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
